// File: rtl/card_pkg.sv
// Shared types and constants for the card requester and the dealer score logic.
package card_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_GAP,
      ST_DONE,
      ST_ERR
   } state_t;

   localparam logic [3:0] ACE         = 4'd1;
   localparam logic [3:0] TEN         = 4'd10;
   localparam logic [3:0] KING        = 4'd13;
   localparam logic [3:0] ACE_POINTS  = 4'd11;
   localparam logic [3:0] FACE_POINTS = 4'd10;

   // Only ranks ACE..KING are real cards; 0 and 14..15 are source glitches.
   function automatic logic isLegalRank(input logic [3:0] rank);
      return (rank >= ACE) && (rank <= KING);
   endfunction

endpackage

// File: rtl/card_requester_if.sv
// Handshake bundle between the game FSM, the random card source and the requester.
interface card_requester_if;

   logic       deal_start_i;
   logic       dest_i;
   logic       clear_err_i;
   logic       card_valid_i;
   logic [3:0] card_value_i;
   logic       req_card_o;
   logic [3:0] card_o;
   logic [3:0] points_o;
   logic       dest_o;
   logic       card_ready_o;
   logic       busy_o;
   logic       timeout_err_o;

   modport slave (
      input  deal_start_i, dest_i, clear_err_i, card_valid_i, card_value_i,
      output req_card_o, card_o, points_o, dest_o, card_ready_o, busy_o, timeout_err_o
   );

   modport master (
      output deal_start_i, dest_i, clear_err_i, card_valid_i, card_value_i,
      input  req_card_o, card_o, points_o, dest_o, card_ready_o, busy_o, timeout_err_o
   );

endinterface

// File: rtl/card_points_decoder.sv
// Blackjack rank-to-points conversion; illegal ranks decode to 0 points.
module card_points_decoder
   import card_pkg::*;
(
   input  logic [3:0] i_rank,
   output logic [3:0] o_points
);

   always_comb begin
      o_points = 4'd0;
      if (i_rank == ACE) begin
         o_points = ACE_POINTS;
      end else if ((i_rank > ACE) && (i_rank <= TEN)) begin
         o_points = i_rank;
      end else if ((i_rank > TEN) && (i_rank <= KING)) begin
         o_points = FACE_POINTS;
      end
   end

endmodule

// File: rtl/card_requester.sv
// Fetches one card from the random source per deal request, filtering
// illegal ranks and flagging a sticky error if the source stays silent.
module card_requester
   import card_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)(
   input  logic             clk_cr_i,
   input  logic             rst_cr_i,
   card_requester_if.slave  bus
);

   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] MAX_WAIT  = {CW{1'b1}};

   state_t          r_state;
   state_t          w_nextState;
   logic [CW-1:0]   r_count;
   logic [CW-1:0]   w_nextCount;
   logic            r_destPending;
   logic [3:0]      r_card;
   logic [3:0]      r_points;
   logic            r_dest;
   logic [3:0]      w_points;
   logic            w_legal;
   logic            w_latch;

   card_points_decoder u_decoder (
      .i_rank   (bus.card_value_i),
      .o_points (w_points)
   );

   assign w_legal = isLegalRank(bus.card_value_i);
   assign w_latch = (r_state == ST_REQ) && bus.card_valid_i && w_legal;

   always_ff @(posedge clk_cr_i or posedge rst_cr_i) begin
      if (rst_cr_i) begin
         r_state <= ST_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_nextState;
         r_count <= w_nextCount;
      end
   end

   // A valid card is checked before the timeout so a last-cycle card still wins.
   always_comb begin
      w_nextState = r_state;
      w_nextCount = r_count;
      case (r_state)
         ST_IDLE: begin
            if (bus.deal_start_i) begin
               w_nextState = ST_REQ;
               w_nextCount = '0;
            end
         end
         ST_REQ: begin
            if (bus.card_valid_i) begin
               if (w_legal) begin
                  w_nextState = ST_DONE;
               end else begin
                  w_nextState = ST_GAP;
                  w_nextCount = '0;
               end
            end else if (r_count == LAST_WAIT) begin
               w_nextState = ST_ERR;
            end else if (r_count != MAX_WAIT) begin
               w_nextCount = r_count + CW'(1);
            end
         end
         ST_GAP: begin
            w_nextState = ST_REQ;
         end
         ST_DONE: begin
            w_nextState = ST_IDLE;
         end
         ST_ERR: begin
            if (bus.clear_err_i) begin
               w_nextState = ST_IDLE;
            end
         end
         default: begin
            w_nextState = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_cr_i or posedge rst_cr_i) begin
      if (rst_cr_i) begin
         r_destPending <= 1'b0;
         r_card        <= 4'd0;
         r_points      <= 4'd0;
         r_dest        <= 1'b0;
      end else begin
         if ((r_state == ST_IDLE) && bus.deal_start_i) begin
            r_destPending <= bus.dest_i;
         end
         if (w_latch) begin
            r_card   <= bus.card_value_i;
            r_points <= w_points;
            r_dest   <= r_destPending;
         end
      end
   end

   // Status outputs decode straight from the state so reset clears them at once.
   assign bus.req_card_o    = (r_state == ST_REQ);
   assign bus.card_ready_o  = (r_state == ST_DONE);
   assign bus.busy_o        = (r_state != ST_IDLE);
   assign bus.timeout_err_o = (r_state == ST_ERR);
   assign bus.card_o        = r_card;
   assign bus.points_o      = r_points;
   assign bus.dest_o        = r_dest;

endmodule
